// File: rtl/seq_detect_ctrl_pkg.sv
// Shared state encoding for the sequence-detector controller.
package seq_detect_ctrl_pkg;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/seq_ctrl_piso.sv
// Parallel-in / serial-out shift register, LSB presented first.
module seq_ctrl_piso #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              lsb
);
    logic [WORD_W-1:0] sreg;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= data;
        end else if (shift) begin
            sreg <= {1'b0, sreg[WORD_W-1:1]};
        end
    end

    assign lsb = sreg[0];
endmodule

// File: rtl/seq_detect_ctrl.sv
// Serialises a parallel word into a sequence detector and collects its hits.
//
//   state | meaning
//   IDLE  | waiting for start; results from the last job held
//   CLEAR | det_clr high for one cycle, w_out low
//   SHIFT | one word bit per cycle on w_out, z sampled for the previous bit
//   DRAIN | w_out low, z sampled for the last bit
//   DONE  | done pulse, busy low
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              w_out,
    output logic              det_clr,
    input  logic              z_in,
    output logic [CNT_W-1:0]  hit_count,
    output logic              hit_any,
    output logic [IDX_W-1:0]  first_hit_idx
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [STATE_W-1:0] state, next_state;
    logic [IDX_W-1:0]   bit_idx, sample_idx;
    logic               accept, shift_en, sample;
    logic               w_next, clr_next, done_next;
    logic               piso_lsb;

    seq_ctrl_piso #(.WORD_W(WORD_W)) u_piso (
        .clk   (clk),
        .Reset (Reset),
        .load  (accept),
        .shift (shift_en),
        .data  (data_in),
        .lsb   (piso_lsb)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:  next_state = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: next_state = ST_SHIFT;
            ST_SHIFT: next_state = (bit_idx == LAST_IDX) ? ST_DRAIN : ST_SHIFT;
            ST_DRAIN: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the state being entered.
    always_comb begin
        accept     = (state == ST_IDLE) && start;
        shift_en   = (next_state == ST_SHIFT);
        sample     = ((state == ST_SHIFT) && (bit_idx != '0)) || (state == ST_DRAIN);
        sample_idx = (state == ST_DRAIN) ? LAST_IDX : bit_idx - IDX_W'(1);
        w_next     = (next_state == ST_SHIFT) ? piso_lsb : 1'b0;
        clr_next   = (next_state == ST_CLEAR);
        done_next  = (next_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            w_out         <= 1'b0;
            det_clr       <= 1'b0;
            bit_idx       <= '0;
            hit_count     <= '0;
            hit_any       <= 1'b0;
            first_hit_idx <= '0;
        end else begin
            w_out   <= w_next;
            det_clr <= clr_next;
            done    <= done_next;

            if (accept) begin
                busy <= 1'b1;
            end else if (done_next) begin
                busy <= 1'b0;
            end

            bit_idx <= ((state == ST_SHIFT) && (bit_idx != LAST_IDX)) ?
                       bit_idx + IDX_W'(1) : '0;

            if (accept) begin
                hit_count     <= '0;
                hit_any       <= 1'b0;
                first_hit_idx <= '0;
            end else if (sample && z_in) begin
                if (hit_count != CNT_MAX) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
                if (!hit_any) begin
                    hit_any       <= 1'b1;
                    first_hit_idx <= sample_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed + randomized bench for seq_detect_ctrl against a per-job result model.
module tb_seq_detect_ctrl;
    logic       clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] data_in;
    logic       z_in;
    logic       z_one;
    logic       busy, done, w_out, det_clr, hit_any;
    logic [3:0] hit_count;
    logic [2:0] first_hit_idx;
    logic       busy2, done2, w_out2, det_clr2, hit_any2;
    logic [1:0] hit_count2;
    logic [2:0] first_hit_idx2;

    int n_vec = 0;
    int n_err = 0;

    seq_detect_ctrl #(.WORD_W(8), .CNT_W(4), .IDX_W(3)) dut (
        .clk(clk), .Reset(Reset), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .w_out(w_out), .det_clr(det_clr),
        .z_in(z_in), .hit_count(hit_count), .hit_any(hit_any),
        .first_hit_idx(first_hit_idx)
    );

    // Narrow counter with z stuck high exercises saturation.
    seq_detect_ctrl #(.WORD_W(8), .CNT_W(2), .IDX_W(3)) dut_sat (
        .clk(clk), .Reset(Reset), .start(start), .data_in(data_in),
        .busy(busy2), .done(done2), .w_out(w_out2), .det_clr(det_clr2),
        .z_in(z_one), .hit_count(hit_count2), .hit_any(hit_any2),
        .first_hit_idx(first_hit_idx2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_w_out"}, w_out, 0);
        chk({tag, "_det_clr"}, det_clr, 0);
        chk({tag, "_hit_count"}, hit_count, 0);
        chk({tag, "_hit_any"}, hit_any, 0);
        chk({tag, "_first_idx"}, first_hit_idx, 0);
    endtask

    // One job: start accepted at edge 0; zv[k] is the detector's answer to bit k,
    // presented during cycle k+3. abort_at > 0 resets mid-cycle in that cycle.
    task automatic run_job(input logic [7:0] d, input logic [7:0] zv,
                           input bit noise, input int abort_at);
        int cnt = 0;
        int first = 0;
        bit any = 0;
        int exp_cnt;
        for (int k = 0; k < 8; k++) begin
            if (zv[k]) begin
                if (!any) first = k;
                any = 1;
                cnt++;
            end
        end
        exp_cnt = (cnt > 15) ? 15 : cnt;

        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        z_in    = noise ? 1'($urandom % 2) : 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                Reset = 1'b1;
                start = 1'b0;
                z_in  = 1'b0;
                #1;
                chk_all_zero("abort");
                @(negedge clk);
                Reset = 1'b0;
                @(negedge clk);
                chk("abort_busy_after", busy, 0);
                chk("abort_w_out_after", w_out, 0);
                return;
            end
            chk("det_clr", det_clr, (c == 1));
            chk("w_out", w_out, (c >= 2 && c <= 9) ? d[c-2] : 1'b0);
            chk("busy", busy, (c <= 10));
            chk("done", done, (c == 11));
            if (c >= 11) begin
                chk("hit_count", hit_count, exp_cnt);
                chk("hit_any", hit_any, any);
                chk("first_hit_idx", first_hit_idx, first);
            end
            if (c == 11) begin
                chk("sat_hit_count", hit_count2, 3);
                chk("sat_hit_any", hit_any2, 1);
                chk("sat_first_idx", first_hit_idx2, 0);
            end
            start = (noise && c <= 11) ? 1'($urandom % 2) : 1'b0;
            if (noise) data_in = 8'($urandom);
            z_in = (c >= 3 && c <= 10) ? zv[c-3] : (noise ? 1'($urandom % 2) : 1'b0);
        end
    endtask

    initial begin
        z_one   = 1'b1;
        Reset   = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        z_in    = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        Reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_all_zero("idle");

        run_job(8'hA5, 8'h00, 1'b0, 0);
        run_job(8'hA5, 8'h08, 1'b0, 0);

        // Held results must vanish the instant reset is asserted.
        @(negedge clk);
        chk("held_count", hit_count, 1);
        Reset = 1'b1;
        #1;
        chk_all_zero("midcycle_reset");
        @(negedge clk);
        Reset = 1'b0;

        run_job(8'h5A, 8'h64, 1'b1, 0);
        run_job(8'hC3, 8'h00, 1'b0, 0);
        run_job(8'hFF, 8'hFF, 1'b1, 0);
        run_job(8'h80, 8'h80, 1'b0, 0);

        run_job(8'hA5, 8'hFF, 1'b0, 5);
        run_job(8'h3C, 8'h21, 1'b0, 0);

        for (int j = 0; j < 8; j++) begin
            run_job(8'($urandom), 8'($urandom), 1'b1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
